// File: rtl/vscpu_boot_loader_if.sv
// Byte-stream handshake between a UART/host byte source and the boot loader.
interface vscpu_boot_loader_if;
    logic       i_byte_valid;
    logic [7:0] i_byte_data;
    logic       o_byte_ready;

    modport master (output i_byte_valid, output i_byte_data, input o_byte_ready);
    modport slave  (input i_byte_valid, input i_byte_data, output o_byte_ready);
endinterface

// File: rtl/vscpu_boot_loader.sv
// Boot loader: assembles a big-endian word stream into blram from address 0,
// then releases the CPU and passes its RAM write traffic straight through.
module vscpu_boot_loader #(
    parameter int SIZE  = 14,
    parameter int DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    vscpu_boot_loader_if.slave   byte_if,
    output logic                 o_cpu_rst,
    output logic                 o_done,
    output logic                 o_error,
    output logic [15:0]          o_words_loaded,
    input  logic                 i_cpu_wrEn,
    input  logic [SIZE-1:0]      i_cpu_addr,
    input  logic [31:0]          i_cpu_data,
    output logic                 o_ram_we,
    output logic [SIZE-1:0]      o_ram_addr,
    output logic [31:0]          o_ram_data
);

    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] count_r;
    logic [15:0] word_idx_r;
    logic [1:0]  byte_idx_r;
    logic [31:0] shift_r;
    logic        cpu_rst_r;
    logic        done_r;
    logic        error_r;
    logic        ready_s;
    logic        xfer_s;
    logic [15:0] hdr_count_s;

    // Byte acceptance depends on state only; reset forces ready low.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            S_HDR_HI, S_HDR_LO, S_DATA, S_ERR: ready_s = 1'b1;
            default:                           ready_s = 1'b0;
        endcase
    end

    assign byte_if.o_byte_ready = ready_s & ~rst;
    assign xfer_s               = byte_if.i_byte_valid & ready_s & ~rst;
    assign hdr_count_s          = {count_r[15:8], byte_if.i_byte_data};

    // Next-state logic of the load sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_HDR_HI: begin
                if (xfer_s) state_nxt_s = S_HDR_LO;
                else        state_nxt_s = state_r;
            end
            S_HDR_LO: begin
                if (!xfer_s)                            state_nxt_s = state_r;
                else if (hdr_count_s == 16'd0)          state_nxt_s = S_DONE;
                else if ({1'b0, hdr_count_s} > DEPTH_W) state_nxt_s = S_ERR;
                else                                    state_nxt_s = S_DATA;
            end
            S_DATA: begin
                if (xfer_s && (byte_idx_r == 2'd3)) state_nxt_s = S_WRITE;
                else                                state_nxt_s = state_r;
            end
            S_WRITE: begin
                if ((word_idx_r + 16'd1) == count_r) state_nxt_s = S_DONE;
                else                                 state_nxt_s = S_DATA;
            end
            S_DONE:  state_nxt_s = S_DONE;
            S_ERR:   state_nxt_s = S_ERR;
            default: state_nxt_s = S_HDR_HI;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_HDR_HI;
        else     state_r <= state_nxt_s;
    end

    // Header count, byte assembly, word index and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= 16'd0;
            word_idx_r <= 16'd0;
            byte_idx_r <= 2'd0;
            shift_r    <= 32'd0;
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            if (xfer_s && (state_r == S_HDR_HI)) count_r[15:8] <= byte_if.i_byte_data;
            if (xfer_s && (state_r == S_HDR_LO)) begin
                count_r[7:0] <= byte_if.i_byte_data;
                byte_idx_r   <= 2'd0;
            end
            if (xfer_s && (state_r == S_DATA)) begin
                shift_r    <= {shift_r[23:0], byte_if.i_byte_data};
                byte_idx_r <= byte_idx_r + 2'd1;
            end
            if (state_r == S_WRITE) word_idx_r <= word_idx_r + 16'd1;
            // Flags follow the next state so the CPU leaves reset in the first DONE cycle.
            cpu_rst_r <= (state_nxt_s != S_DONE);
            done_r    <= (state_nxt_s == S_DONE);
            error_r   <= (state_nxt_s == S_ERR);
        end
    end

    // RAM port ownership: loader while writing, CPU pass-through once done.
    always_comb begin
        o_ram_we   = 1'b0;
        o_ram_addr = {SIZE{1'b0}};
        o_ram_data = 32'd0;
        case (state_r)
            S_WRITE: begin
                o_ram_we   = 1'b1;
                o_ram_addr = word_idx_r[SIZE-1:0];
                o_ram_data = shift_r;
            end
            S_DONE: begin
                o_ram_we   = i_cpu_wrEn;
                o_ram_addr = i_cpu_addr;
                o_ram_data = i_cpu_data;
            end
            default: begin
                o_ram_we   = 1'b0;
                o_ram_addr = {SIZE{1'b0}};
                o_ram_data = 32'd0;
            end
        endcase
    end

    assign o_cpu_rst      = cpu_rst_r;
    assign o_done         = done_r;
    assign o_error        = error_r;
    assign o_words_loaded = word_idx_r;

endmodule
